// File: rtl/vdp_vram_port_ctrl.sv
// vdp_vram_port_ctrl: Beaker8 VDP I/O-port decode, VRAM pointer and VRAM arbiter.
// Define VDP_READ_PREFETCH_EN to add the background read prefetch latch.
module vdp_vram_port_ctrl #(
    parameter int ADDR_W       = 14,
    parameter int DISP_MAX_RUN = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              io_sel,
    input  logic              io_wr,
    input  logic [7:0]        io_addr,
    input  logic [7:0]        io_wdata,
    output logic [7:0]        io_rdata,
    output logic              io_ready,
    input  logic              disp_req,
    input  logic [ADDR_W-1:0] disp_addr,
    output logic              disp_ack,
    output logic              disp_valid,
    output logic [7:0]        disp_data,
    output logic [ADDR_W-1:0] vram_addr,
    output logic              vram_we,
    output logic [7:0]        vram_wdata,
    input  logic [7:0]        vram_rdata,
    output logic [7:0]        vdp_mode
);
    localparam int RUN_W = $clog2(DISP_MAX_RUN + 1);

    typedef enum logic [1:0] {IDLE, RD_ISSUE, RD_WAIT} state_t;

    state_t            state;
    state_t            state_nxt;
    logic [7:0]        mode_q;
    logic [ADDR_W-1:0] ptr;
    logic              buf_valid;
    logic [ADDR_W-1:0] buf_addr;
    logic [7:0]        buf_data;
    logic [RUN_W-1:0]  run_cnt;
    logic              disp_valid_q;

    logic is_p00, is_p01, is_p40, is_p41, is_p42;
    logic sel_rd, sel_wr;
    logic ptr_lo_wr, ptr_hi_wr, wr_accept;
    logic rd_start, rd_done;
    logic cpu_pend, disp_grant, drain, rd_grant, pf_grant;
    logic pf_hit, pf_want, pf_take;
    logic [7:0] pf_q;
    logic [7:0] rd_val;

    assign is_p00 = io_addr == 8'h00;
    assign is_p01 = io_addr == 8'h01;
    assign is_p40 = io_addr == 8'h40;
    assign is_p41 = io_addr == 8'h41;
    assign is_p42 = io_addr == 8'h42;

    assign sel_wr    = io_sel && io_wr;
    assign sel_rd    = io_sel && !io_wr;
    assign ptr_lo_wr = sel_wr && is_p41;
    assign ptr_hi_wr = sel_wr && is_p42;
    assign pf_take   = pf_hit && sel_rd && is_p01;
    assign rd_start  = state == IDLE && sel_rd && is_p01 && !pf_hit;
    assign rd_done   = state == RD_WAIT;

    // Display wins unless it has already held off a waiting CPU op too long.
    assign cpu_pend   = buf_valid || state == RD_ISSUE || pf_want;
    assign disp_grant = disp_req &&
                        (!cpu_pend || run_cnt < RUN_W'(DISP_MAX_RUN));
    assign drain      = !disp_grant && buf_valid;
    assign rd_grant   = !disp_grant && !buf_valid && state == RD_ISSUE;
    assign pf_grant   = !disp_grant && !buf_valid && pf_want;
    assign wr_accept  = sel_wr && is_p00 && (!buf_valid || drain);

    always_ff @(posedge clk) begin
        if (reset) begin
            mode_q       <= '0;
            ptr          <= '0;
            buf_valid    <= 1'b0;
            buf_addr     <= '0;
            buf_data     <= '0;
            run_cnt      <= '0;
            disp_valid_q <= 1'b0;
        end else begin
            if (sel_wr && is_p40)
                mode_q <= io_wdata;

            if (ptr_lo_wr)
                ptr <= {ptr[ADDR_W-1:8], io_wdata};
            else if (ptr_hi_wr)
                ptr <= {io_wdata[ADDR_W-9:0], ptr[7:0]};
            else if (wr_accept || rd_done || pf_take)
                ptr <= ptr + ADDR_W'(1);

            if (wr_accept) begin
                buf_valid <= 1'b1;
                buf_addr  <= ptr;
                buf_data  <= io_wdata;
            end else if (drain) begin
                buf_valid <= 1'b0;
            end

            if (disp_grant && cpu_pend)
                run_cnt <= run_cnt + RUN_W'(1);
            else if (!cpu_pend || drain || rd_grant || pf_grant)
                run_cnt <= '0;

            disp_valid_q <= disp_grant;
        end
    end

`ifdef VDP_READ_PREFETCH_EN
    logic       pf_valid;
    logic       pf_pend;
    logic       pf_wait;
    logic [7:0] pf_data;
    logic       pf_inval;

    assign pf_hit   = pf_valid && state == IDLE;
    assign pf_want  = pf_pend && state == IDLE;
    assign pf_q     = pf_data;
    assign pf_inval = wr_accept || ptr_lo_wr || ptr_hi_wr;

    always_ff @(posedge clk) begin
        if (reset) begin
            pf_valid <= 1'b0;
            pf_pend  <= 1'b0;
            pf_wait  <= 1'b0;
            pf_data  <= '0;
        end else if (pf_inval) begin
            pf_valid <= 1'b0;
            pf_wait  <= 1'b0;
            pf_pend  <= ptr_lo_wr || ptr_hi_wr;
        end else if (rd_done || pf_take) begin
            pf_valid <= 1'b0;
            pf_wait  <= 1'b0;
            pf_pend  <= 1'b1;
        end else begin
            pf_wait <= pf_grant;
            if (pf_grant)
                pf_pend <= 1'b0;
            if (pf_wait) begin
                pf_valid <= 1'b1;
                pf_data  <= vram_rdata;
            end
        end
    end
`else
    assign pf_hit  = 1'b0;
    assign pf_want = 1'b0;
    assign pf_q    = 8'h00;
`endif

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE:     if (rd_start) state_nxt = RD_ISSUE;
            RD_ISSUE: if (rd_grant) state_nxt = RD_WAIT;
            RD_WAIT:  state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
    end

    always_comb begin
        io_ready   = 1'b0;
        io_rdata   = 8'h00;
        rd_val     = 8'hFF;
        vram_addr  = '0;
        vram_we    = 1'b0;
        vram_wdata = 8'h00;
        disp_ack   = 1'b0;
        if (!reset) begin
            disp_ack = disp_grant;
            if (disp_grant) begin
                vram_addr = disp_addr;
            end else if (drain) begin
                vram_addr  = buf_addr;
                vram_we    = 1'b1;
                vram_wdata = buf_data;
            end else if (rd_grant || pf_grant) begin
                vram_addr = ptr;
            end

            if (io_sel) begin
                unique case (1'b1)
                    is_p00: io_ready = io_wr ? wr_accept : 1'b1;
                    is_p01: begin
                        io_ready = io_wr || rd_done || pf_hit;
                        if (rd_done)
                            rd_val = vram_rdata;
                        else if (pf_hit)
                            rd_val = pf_q;
                        else
                            rd_val = 8'h00;
                    end
                    is_p40: begin
                        io_ready = 1'b1;
                        rd_val   = mode_q;
                    end
                    is_p41: begin
                        io_ready = 1'b1;
                        rd_val   = ptr[7:0];
                    end
                    is_p42: begin
                        io_ready = 1'b1;
                        rd_val   = 8'(ptr >> 8);
                    end
                    default: io_ready = 1'b1;
                endcase
                if (!io_wr)
                    io_rdata = rd_val;
            end
        end
    end

    assign disp_valid = disp_valid_q;
    assign disp_data  = disp_valid_q ? vram_rdata : 8'h00;
    assign vdp_mode   = mode_q;

endmodule

// File: tb/tb_vdp_vram_port_ctrl.sv
// tb_vdp_vram_port_ctrl: directed bench for the VDP port controller.
// Models the synchronous VRAM macro and checks hand-computed results.
module tb_vdp_vram_port_ctrl;
    localparam int AW = 14;

    logic          clk = 1'b0;
    logic          reset;
    logic          io_sel;
    logic          io_wr;
    logic [7:0]    io_addr;
    logic [7:0]    io_wdata;
    logic [7:0]    io_rdata;
    logic          io_ready;
    logic          disp_req;
    logic [AW-1:0] disp_addr;
    logic          disp_ack;
    logic          disp_valid;
    logic [7:0]    disp_data;
    logic [AW-1:0] vram_addr;
    logic          vram_we;
    logic [7:0]    vram_wdata;
    logic [7:0]    vram_rdata = 8'h00;
    logic [7:0]    vdp_mode;

    logic [7:0] mem [0:(1<<AW)-1];

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vdp_vram_port_ctrl #(.ADDR_W(AW), .DISP_MAX_RUN(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .io_sel     (io_sel),
        .io_wr      (io_wr),
        .io_addr    (io_addr),
        .io_wdata   (io_wdata),
        .io_rdata   (io_rdata),
        .io_ready   (io_ready),
        .disp_req   (disp_req),
        .disp_addr  (disp_addr),
        .disp_ack   (disp_ack),
        .disp_valid (disp_valid),
        .disp_data  (disp_data),
        .vram_addr  (vram_addr),
        .vram_we    (vram_we),
        .vram_wdata (vram_wdata),
        .vram_rdata (vram_rdata),
        .vdp_mode   (vdp_mode)
    );

    always @(posedge clk) begin
        if (vram_we)
            mem[vram_addr] <= vram_wdata;
        vram_rdata <= mem[vram_addr];
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic port_wr(input logic [7:0] a, input logic [7:0] d,
                           output int lat);
        io_sel = 1'b1; io_wr = 1'b1; io_addr = a; io_wdata = d; lat = 0;
        @(negedge clk);
        while (!io_ready && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        @(posedge clk); #1;
        io_sel = 1'b0;
        if (lat >= 60) begin
            n_cmp++; n_bad++;
            $display("FAIL wr_timeout port %h: no io_ready in 60 cycles", a);
        end
    endtask

    task automatic port_rd(input logic [7:0] a, output logic [7:0] d,
                           output int lat);
        io_sel = 1'b1; io_wr = 1'b0; io_addr = a; lat = 0;
        @(negedge clk);
        while (!io_ready && lat < 60) begin
            @(negedge clk);
            lat++;
        end
        d = io_rdata;
        @(posedge clk); #1;
        io_sel = 1'b0;
        if (lat >= 60) begin
            n_cmp++; n_bad++;
            $display("FAIL rd_timeout port %h: no io_ready in 60 cycles", a);
        end
    endtask

    task automatic test_reset();
        logic [7:0] d;
        int lat;
        reset = 1'b1; io_sel = 1'b0; io_wr = 1'b0;
        io_addr = 8'h00; io_wdata = 8'h00;
        disp_req = 1'b1; disp_addr = 14'h0200;
        idle(2);
        @(negedge clk);
        n_cmp++;
        if ({io_ready, vram_we, disp_ack} !== 3'b000) begin
            n_bad++;
            $display("FAIL rst_ctl got %b want 000", {io_ready, vram_we, disp_ack});
        end
        n_cmp++;
        if (vram_addr !== 14'h0 || io_rdata !== 8'h00 || vram_wdata !== 8'h00) begin
            n_bad++;
            $display("FAIL rst_data got %h/%h/%h want 0", vram_addr, io_rdata, vram_wdata);
        end
        @(posedge clk); #1;
        reset = 1'b0; disp_req = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (disp_valid !== 1'b0 || vdp_mode !== 8'h00) begin
            n_bad++;
            $display("FAIL rst_out got valid=%b mode=%h want 0/00", disp_valid, vdp_mode);
        end
        @(posedge clk); #1;
        port_rd(8'h41, d, lat);
        n_cmp++;
        if (d !== 8'h00 || lat !== 0) begin
            n_bad++;
            $display("FAIL rst_ptr got %h lat %0d want 00 lat 0", d, lat);
        end
    endtask

    task automatic test_seq_write();
        logic [7:0] d;
        int lat;
        port_wr(8'h40, 8'h14, lat);
        port_wr(8'h41, 8'h00, lat);
        port_wr(8'h42, 8'h00, lat);
        for (int i = 0; i < 8; i++) begin
            port_wr(8'h00, 8'h00, lat);
            n_cmp++;
            if (lat !== 0) begin
                n_bad++;
                $display("FAIL seq_ready #%0d got lat %0d want 0", i, lat);
            end
        end
        idle(2);
        n_cmp++;
        if (vdp_mode !== 8'h14) begin
            n_bad++;
            $display("FAIL seq_mode got %h want 14", vdp_mode);
        end
        for (int i = 0; i < 8; i++) begin
            n_cmp++;
            if (mem[i] !== 8'h00) begin
                n_bad++;
                $display("FAIL seq_mem[%0d] got %h want 00", i, mem[i]);
            end
        end
        n_cmp++;
        if (mem[8] !== 8'hEE) begin
            n_bad++;
            $display("FAIL seq_mem[8] got %h want EE", mem[8]);
        end
        port_rd(8'h41, d, lat);
        n_cmp++;
        if (d !== 8'h08) begin
            n_bad++;
            $display("FAIL seq_ptr_lo got %h want 08", d);
        end
        port_rd(8'h40, d, lat);
        n_cmp++;
        if (d !== 8'h14) begin
            n_bad++;
            $display("FAIL seq_rd_mode got %h want 14", d);
        end
    endtask

    task automatic test_unmapped();
        logic [7:0] d;
        int lat;
        port_rd(8'h55, d, lat);
        n_cmp++;
        if (d !== 8'hFF || lat !== 0) begin
            n_bad++;
            $display("FAIL unm_rd got %h lat %0d want FF lat 0", d, lat);
        end
        port_wr(8'h55, 8'hAB, lat);
        port_rd(8'h00, d, lat);
        n_cmp++;
        if (d !== 8'hFF || lat !== 0) begin
            n_bad++;
            $display("FAIL p00_rd got %h lat %0d want FF lat 0", d, lat);
        end
        port_wr(8'h01, 8'hCD, lat);
        n_cmp++;
        if (lat !== 0) begin
            n_bad++;
            $display("FAIL p01_wr got lat %0d want 0", lat);
        end
        port_rd(8'h41, d, lat);
        n_cmp++;
        if (d !== 8'h08 || vdp_mode !== 8'h14) begin
            n_bad++;
            $display("FAIL unm_side got ptr %h mode %h want 08/14", d, vdp_mode);
        end
    endtask

    task automatic test_wrap();
        logic [7:0] d;
        int lat;
        port_wr(8'h41, 8'hFF, lat);
        port_wr(8'h42, 8'hFF, lat);
        port_rd(8'h42, d, lat);
        n_cmp++;
        if (d !== 8'h3F) begin
            n_bad++;
            $display("FAIL wrap_hi got %h want 3F", d);
        end
        port_wr(8'h00, 8'hAA, lat);
        port_wr(8'h00, 8'hBB, lat);
        idle(2);
        n_cmp++;
        if (mem[14'h3FFF] !== 8'hAA || mem[0] !== 8'hBB) begin
            n_bad++;
            $display("FAIL wrap_mem got %h,%h want AA,BB", mem[14'h3FFF], mem[0]);
        end
        port_rd(8'h41, d, lat);
        n_cmp++;
        if (d !== 8'h01) begin
            n_bad++;
            $display("FAIL wrap_ptr_lo got %h want 01", d);
        end
        port_rd(8'h42, d, lat);
        n_cmp++;
        if (d !== 8'h00) begin
            n_bad++;
            $display("FAIL wrap_ptr_hi got %h want 00", d);
        end
    endtask

    task automatic test_read_after_write();
        logic [7:0] d;
        int lat;
        port_wr(8'h41, 8'h00, lat);
        port_wr(8'h42, 8'h01, lat);
        port_wr(8'h00, 8'h5A, lat);
        port_wr(8'h41, 8'h00, lat);
        port_rd(8'h01, d, lat);
        n_cmp++;
        if (d !== 8'h5A || lat !== 2) begin
            n_bad++;
            $display("FAIL raw_fast got %h lat %0d want 5A lat 2", d, lat);
        end
        idle(3);
        disp_addr = 14'h0200;
        disp_req  = 1'b1;
        port_wr(8'h00, 8'hA5, lat);
        port_wr(8'h41, 8'h01, lat);
        port_rd(8'h01, d, lat);
        disp_req = 1'b0;
        n_cmp++;
        if (d !== 8'hA5 || lat !== 9) begin
            n_bad++;
            $display("FAIL raw_disp got %h lat %0d want A5 lat 9", d, lat);
        end
        port_rd(8'h41, d, lat);
        n_cmp++;
        if (d !== 8'h02) begin
            n_bad++;
            $display("FAIL raw_ptr got %h want 02", d);
        end
    endtask

    task automatic test_arbitration();
        int l1, l2, lat;
        logic [11:0] ack_v, we_v;
        port_wr(8'h41, 8'h00, lat);
        port_wr(8'h42, 8'h03, lat);
        idle(3);
        disp_addr = 14'h0200;
        disp_req  = 1'b1;
        ack_v = '0; we_v = '0;
        fork
            begin
                port_wr(8'h00, 8'h77, l1);
                port_wr(8'h00, 8'h78, l2);
            end
            begin
                for (int k = 0; k < 12; k++) begin
                    @(negedge clk);
                    ack_v[k] = disp_ack;
                    we_v[k]  = vram_we;
                    if (k > 0) begin
                        n_cmp++;
                        if (disp_valid !== ack_v[k-1]) begin
                            n_bad++;
                            $display("FAIL arb_valid c%0d got %b want %b", k, disp_valid, ack_v[k-1]);
                        end
                    end
                    if (disp_valid === 1'b1) begin
                        n_cmp++;
                        if (disp_data !== 8'hC3) begin
                            n_bad++;
                            $display("FAIL arb_data c%0d got %h want C3", k, disp_data);
                        end
                    end
                end
            end
        join
        @(posedge clk); #1;
        disp_req = 1'b0;
        n_cmp++;
        if (ack_v !== 12'hBDF) begin
            n_bad++;
            $display("FAIL arb_ack got %h want BDF", ack_v);
        end
        n_cmp++;
        if (we_v !== 12'h420) begin
            n_bad++;
            $display("FAIL arb_we got %h want 420", we_v);
        end
        n_cmp++;
        if (l1 !== 0 || l2 !== 4) begin
            n_bad++;
            $display("FAIL arb_lat got %0d,%0d want 0,4", l1, l2);
        end
        idle(2);
        n_cmp++;
        if (mem[14'h0300] !== 8'h77 || mem[14'h0301] !== 8'h78) begin
            n_bad++;
            $display("FAIL arb_mem got %h,%h want 77,78", mem[14'h0300], mem[14'h0301]);
        end
    endtask

    task automatic test_reset_midop();
        logic [7:0] d;
        int lat, we_cnt;
        port_wr(8'h41, 8'h00, lat);
        port_wr(8'h42, 8'h04, lat);
        idle(3);
        disp_addr = 14'h0200;
        disp_req  = 1'b1;
        port_wr(8'h00, 8'h99, lat);
        reset = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({vram_we, disp_ack, io_ready} !== 3'b000) begin
            n_bad++;
            $display("FAIL mid_rst got %b want 000", {vram_we, disp_ack, io_ready});
        end
        @(posedge clk); #1;
        reset = 1'b0; disp_req = 1'b0;
        we_cnt = 0;
        @(negedge clk);
        n_cmp++;
        if (disp_valid !== 1'b0) begin
            n_bad++;
            $display("FAIL mid_valid got %b want 0", disp_valid);
        end
        for (int k = 0; k < 6; k++) begin
            if (vram_we === 1'b1) we_cnt++;
            @(negedge clk);
        end
        @(posedge clk); #1;
        n_cmp++;
        if (we_cnt !== 0 || mem[14'h0400] !== 8'hEE) begin
            n_bad++;
            $display("FAIL mid_we got %0d writes mem %h want 0 writes EE", we_cnt, mem[14'h0400]);
        end
        n_cmp++;
        if (vdp_mode !== 8'h00) begin
            n_bad++;
            $display("FAIL mid_mode got %h want 00", vdp_mode);
        end
        port_rd(8'h41, d, lat);
        n_cmp++;
        if (d !== 8'h00) begin
            n_bad++;
            $display("FAIL mid_ptr_lo got %h want 00", d);
        end
        port_rd(8'h42, d, lat);
        n_cmp++;
        if (d !== 8'h00) begin
            n_bad++;
            $display("FAIL mid_ptr_hi got %h want 00", d);
        end
    endtask

    task automatic test_read_seq();
        logic [7:0] d;
        int lat, want_lat;
`ifdef VDP_READ_PREFETCH_EN
        want_lat = 0;
`else
        want_lat = 2;
`endif
        port_wr(8'h41, 8'h10, lat);
        port_wr(8'h42, 8'h00, lat);
        idle(3);
        port_rd(8'h01, d, lat);
        n_cmp++;
        if (d !== 8'h11 || lat !== want_lat) begin
            n_bad++;
            $display("FAIL rd1 got %h lat %0d want 11 lat %0d", d, lat, want_lat);
        end
        idle(3);
        port_rd(8'h01, d, lat);
        n_cmp++;
        if (d !== 8'h22 || lat !== want_lat) begin
            n_bad++;
            $display("FAIL rd2 got %h lat %0d want 22 lat %0d", d, lat, want_lat);
        end
        port_rd(8'h41, d, lat);
        n_cmp++;
        if (d !== 8'h12) begin
            n_bad++;
            $display("FAIL rd_ptr got %h want 12", d);
        end
    endtask

    initial begin
        for (int i = 0; i < (1 << AW); i++)
            mem[i] <= 8'hEE;
        mem[14'h0200] <= 8'hC3;
        mem[14'h0010] <= 8'h11;
        mem[14'h0011] <= 8'h22;
        test_reset();
        test_seq_write();
        test_unmapped();
        test_wrap();
        test_read_after_write();
        test_arbitration();
        test_reset_midop();
        test_read_seq();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
